coprocessor_riscv_lsu: RTL
==========================

COPROCESSOR_RISCV_LSU -- requirements
Module: coprocessor_riscv_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 5120, meaning data RAM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning RAM word-address width.
REQ-003 SHALL have port clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: core request handshake.
REQ-006 SHALL have ports req_addr in 32 (byte address), req_we in 1 (1 = store), req_size in 2 (0 byte, 1 half, 2 word, 3 illegal), req_unsigned in 1 (zero-extend loads), req_wdata in 32 (store data, right-aligned).
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-008 SHALL have ports rsp_rdata out 32 (extended load data, 0 for stores and faults) and rsp_fault out 2 (00 ok, 01 misaligned/illegal size, 10 out-of-range).
REQ-009 SHALL have RAM-side ports mem_address out ADDR_W, mem_byteenable out 4, mem_chipselect out 1, mem_write out 1, mem_debugaccess out 1, mem_writedata out 32, mem_clken out 1, and mem_readdata in 32.

Function
REQ-010 SHALL implement states IDLE, RD_WAIT, RESP; req_ready = 1 only in IDLE with reset_n high.
REQ-011 SHALL accept a request on the cycle req_valid & req_ready are both high.
REQ-012 SHALL flag misaligned when size 1 with addr[0] = 1, size 2 with addr[1:0] != 0, or size 3; misaligned takes priority over out-of-range.
REQ-013 SHALL flag out-of-range when req_addr >= 4*DEPTH_WORDS (20480 by default).
REQ-014 SHALL, on accepting a faulted request, assert no mem_chipselect and go IDLE -> RESP.
REQ-015 SHALL, on the accept cycle of a valid request, combinationally drive mem_chipselect = 1, mem_address = req_addr[ADDR_W+1:2], and mem_byteenable = 0001/0010/0100/1000 per addr[1:0] for bytes, 0011/1100 per addr[1] for halves, 1111 for words.
REQ-016 SHALL, for stores, drive mem_write = mem_debugaccess = 1 on the accept cycle only, with mem_writedata = req_wdata replicated to every lane (byte x4, half x2), then go IDLE -> RESP.
REQ-017 SHALL, for loads, go IDLE -> RD_WAIT; in RD_WAIT sample mem_readdata, select the lane by the registered addr[1:0], sign- or zero-extend per req_unsigned, register into rsp_rdata, and go RESP.
REQ-018 SHALL tie mem_clken = 1, and SHALL drive mem_chipselect, mem_write and mem_debugaccess to 0 outside the accept cycle.
REQ-019 SHALL hold rsp_valid = 1 in RESP with stable rsp_rdata/rsp_fault until rsp_ready, then return to IDLE; no new request is accepted in that cycle.
REQ-020 SHALL meet latency from accept edge to rsp_valid of 1 cycle for stores and faults and 2 cycles for loads, with at most one transaction outstanding.

Reset
REQ-021 SHALL, while reset_n is low at a clock edge, set state IDLE, rsp_valid 0, rsp_rdata 0, rsp_fault 00.
REQ-022 SHALL hold req_ready 0 and all mem_* strobes 0 while reset_n is low, including a reset mid-load (RD_WAIT) or mid-response (RESP); the pending transaction is dropped with no response.

Structure
REQ-023 SHALL place size encodings, fault codes, state encoding and the DEPTH_WORDS/ADDR_W defaults in shared package coprocessor_riscv_pkg.
REQ-024 SHALL implement lane select and extension as sub-module coprocessor_riscv_load_align (combinational, 32-bit word + offset + size + unsigned -> 32-bit result).

Verification
REQ-025 SHALL cover a word store then load: sw 0xDEADBEEF @0x0010 -> mem_byteenable 1111, mem_address 4; lw @0x0010 -> rsp_rdata 0xDEADBEEF two cycles after accept.
REQ-026 SHALL cover byte sign extension: store 0x80 at byte 0x0013; lb @0x0013 -> 0xFFFFFF80; lbu -> 0x00000080; store byteenable 1000.
REQ-027 SHALL cover faults: lh @0x0001 -> rsp_fault 01, no chipselect; lw @0x5000 -> rsp_fault 10; lw @0x4FFC -> ok.
REQ-028 SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-029 SHALL cover reset in RD_WAIT: reset_n low one cycle -> rsp_valid never asserted, IDLE with req_ready 1 on the cycle after release.

Source files
------------

// File: rtl/coprocessor_riscv_pkg.sv
// Shared types and defaults for the coprocessor RISC-V load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: access-size and fault encodings, LSU state encoding, the latched
// load metadata struct, default RAM geometry and a byte-enable helper.
package coprocessor_riscv_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 5120;
  localparam int unsigned ADDR_W_DEF      = 13;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // What the read-return cycle needs to know about the load it is finishing.
  typedef struct packed {
    logic [1:0] offset;
    size_e      size;
    logic       is_unsigned;
  } ld_meta_t;

  // Lane strobes for an aligned access; callers only use it after the
  // alignment check has passed.
  function automatic logic [3:0] byte_enable(input logic [1:0] off, input size_e sz);
    logic [3:0] be;
    be = 4'b0000;
    unique case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/coprocessor_riscv_load_align.sv
// Load lane select and sign/zero extension of a 32-bit RAM word.
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: word_i raw RAM word, offset_i byte offset, size_i access size,
//        unsigned_i zero-extend when set, data_o right-aligned extended result.
module coprocessor_riscv_load_align
  import coprocessor_riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    unique case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    unique case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/coprocessor_riscv_lsu.sv
// Load/store unit bridging a core request port to a single-port sync-read data RAM.
// Latency: accept edge to rsp_valid is 1 cycle for stores/faults, 2 for loads.
// Backpressure: one transaction in flight; req_ready low until the response is taken.
// Ports: req_* core request (byte address, size, store data), rsp_* response
//        (extended load data, fault code), mem_* RAM strobes driven on the accept cycle.
module coprocessor_riscv_lsu
  import coprocessor_riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  // Compared at 34 bits so a large DEPTH_WORDS cannot wrap the limit.
  localparam logic [33:0] RANGE_BYTES = 34'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  fault_e      rsp_fault_q, rsp_fault_d;
  ld_meta_t    meta_q, meta_d;

  size_e       req_sz;
  fault_e      req_fault;
  logic [31:0] load_data;

  assign req_sz = size_e'(req_size);

  // Misalignment is decided first so it wins over out-of-range.
  always_comb begin
    req_fault = FLT_OK;
    unique case (req_sz)
      SZ_BYTE: req_fault = FLT_OK;
      SZ_HALF: req_fault = req_addr[0] ? FLT_MISALIGN : FLT_OK;
      SZ_WORD: req_fault = (req_addr[1:0] != 2'b00) ? FLT_MISALIGN : FLT_OK;
      default: req_fault = FLT_MISALIGN;
    endcase
    if (req_fault == FLT_OK && {2'b00, req_addr} >= RANGE_BYTES) begin
      req_fault = FLT_RANGE;
    end
  end

  // Address and write data follow the request bus; only the strobes qualify them.
  assign mem_address = req_addr[ADDR_W+1:2];
  assign mem_clken   = 1'b1;

  always_comb begin
    mem_writedata = req_wdata;
    unique case (req_sz)
      SZ_BYTE: mem_writedata = {4{req_wdata[7:0]}};
      SZ_HALF: mem_writedata = {2{req_wdata[15:0]}};
      default: mem_writedata = req_wdata;
    endcase
  end

  // RAM returns the word one cycle after the accept; lane choice uses the
  // latched offset since the request bus may already have moved on.
  coprocessor_riscv_load_align u_align (
    .word_i     (mem_readdata),
    .offset_i   (meta_q.offset),
    .size_i     (meta_q.size),
    .unsigned_i (meta_q.is_unsigned),
    .data_o     (load_data)
  );

  always_comb begin
    state_d         = state_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_fault_d     = rsp_fault_q;
    meta_d          = meta_q;
    req_ready       = 1'b0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_debugaccess = 1'b0;
    mem_byteenable  = 4'b0000;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = reset_n;
        if (req_valid && reset_n) begin
          rsp_rdata_d = '0;
          rsp_fault_d = req_fault;
          if (req_fault != FLT_OK) begin
            state_d = ST_RESP;
          end else begin
            mem_chipselect = 1'b1;
            mem_byteenable = byte_enable(req_addr[1:0], req_sz);
            if (req_we) begin
              mem_write       = 1'b1;
              mem_debugaccess = 1'b1;
              state_d         = ST_RESP;
            end else begin
              meta_d.offset      = req_addr[1:0];
              meta_d.size        = req_sz;
              meta_d.is_unsigned = req_unsigned;
              state_d            = ST_RD_WAIT;
            end
          end
        end
      end

      ST_RD_WAIT: begin
        rsp_rdata_d = load_data;
        rsp_fault_d = FLT_OK;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FLT_OK;
      meta_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      meta_q      <= meta_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
